// File: rtl/target_queue.sv
// target_queue: FIFO of pending on-screen targets (shape, x, y, target time).
// Entries are pushed by the SPI packet decoder at the tail. The head entry is
// removed either by a hit command (pop_req) or automatically once its target
// time lies MISS_WINDOW or more ticks in the past (wrap-aware, signed age).
// Renderers read entries oldest-first through a combinational indexed port.
//
// Optional feature, enabled by defining TARGET_QUEUE_DROP_OLDEST_EN:
//   push_ready is tied high and a push into a full queue overwrites the
//   oldest entry instead of being refused. overflow is still flagged.
module target_queue #(
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 8,
   parameter int IDX_W       = $clog2(DEPTH),
   parameter int TIME_LSB    = 3,
   parameter int TIME_W      = 8,
   parameter int MISS_WINDOW = 8
) (
   input  logic              pxl_clk,
   input  logic              reset_b,
   input  logic [TIME_W-1:0] cur_time,
   input  logic              push_valid,
   input  logic [DATA_W-1:0] push_data,
   output logic              push_ready,
   input  logic              pop_req,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic [IDX_W:0]    count,
   output logic              empty,
   output logic              full,
   output logic              overflow,
   output logic              hit_pulse,
   output logic              miss_pulse
);

   localparam logic [IDX_W:0]    DEPTH_CNT = (IDX_W+1)'(DEPTH);
   localparam logic [TIME_W-1:0] MISS_W    = TIME_W'(MISS_WINDOW);

   // Storage (not reset) and control state
   logic [DATA_W-1:0] mem [DEPTH];

   logic [IDX_W-1:0] head_q,     head_d;
   logic [IDX_W-1:0] tail_q,     tail_d;
   logic [IDX_W:0]   count_q,    count_d;
   logic             overflow_q, overflow_d;
   logic             hit_q,      hit_d;
   logic             miss_q,     miss_d;

   // Decoded status and per-cycle events
   logic              full_w;
   logic              empty_w;
   logic [TIME_W-1:0] head_time;
   logic [TIME_W-1:0] age;
   logic              expired;
   logic              remove;
   logic              push_fire;
   logic              overwrite;
   logic [IDX_W-1:0]  rd_addr;

   assign full_w  = (count_q == DEPTH_CNT);
   assign empty_w = (count_q == '0);

   // Age of the head entry, taken mod 2^TIME_W and read as a signed value so
   // that a wrapped cur_time still yields a small positive age.
   assign head_time = mem[head_q][TIME_LSB +: TIME_W];
   assign age       = cur_time - head_time;
   assign expired   = !empty_w && !age[TIME_W-1] && (age >= MISS_W);

   assign remove = !empty_w && (pop_req || expired);

`ifdef TARGET_QUEUE_DROP_OLDEST_EN
   assign push_ready = 1'b1;
   assign overwrite  = push_valid && full_w;
`else
   assign push_ready = !full_w;
   assign overwrite  = 1'b0;
`endif

   assign push_fire = push_valid && push_ready;

   // Next-state decode for pointers, count, sticky overflow and event pulses
   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      hit_d      = 1'b0;
      miss_d     = 1'b0;

      if (push_valid && full_w) begin
         overflow_d = 1'b1;
      end

      if (push_fire) begin
         tail_d = tail_q + IDX_W'(1);
      end

      if (remove) begin
         head_d = head_q + IDX_W'(1);
         hit_d  = pop_req;
         miss_d = !pop_req;
      end

      if (overwrite) begin
         // Full-queue push drops the oldest surviving entry: with a removal
         // in the same cycle the head moves past two entries, so the net
         // count falls by one; without one the head steps once and count
         // stays at DEPTH. The dropped entry never produces a miss pulse.
         if (remove) begin
            head_d  = head_q + IDX_W'(2);
            count_d = count_q - (IDX_W+1)'(1);
         end else begin
            head_d  = head_q + IDX_W'(1);
         end
      end else begin
         unique case ({push_fire, remove})
            2'b10:   count_d = count_q + (IDX_W+1)'(1);
            2'b01:   count_d = count_q - (IDX_W+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control state registers with synchronous active-low reset
   always_ff @(posedge pxl_clk) begin
      if (!reset_b) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         hit_q      <= 1'b0;
         miss_q     <= 1'b0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         hit_q      <= hit_d;
         miss_q     <= miss_d;
      end
   end

   // Entry storage: write accepted pushes at the tail; reset-cycle pushes dropped
   always_ff @(posedge pxl_clk) begin
      if (reset_b && push_fire) begin
         mem[tail_q] <= push_data;
      end
   end

   // Oldest-first combinational read port
   assign rd_addr  = head_q + rd_idx;
   assign rd_data  = mem[rd_addr];
   assign rd_valid = ({1'b0, rd_idx} < count_q);

   assign count      = count_q;
   assign empty      = empty_w;
   assign full       = full_w;
   assign overflow   = overflow_q;
   assign hit_pulse  = hit_q;
   assign miss_pulse = miss_q;

endmodule

// File: tb/tb_target_queue.sv
// Directed, table-driven bench for target_queue (default build).
// Each table row is one clock cycle: inputs are driven after the falling edge
// and the outputs checked 1 ns later reflect the state left by earlier rows.
module tb_target_queue;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 8;
   localparam int IDX_W  = 3;
   localparam int TIME_W = 8;

   logic              pxl_clk = 1'b0;
   logic              reset_b;
   logic [TIME_W-1:0] cur_time;
   logic              push_valid;
   logic [DATA_W-1:0] push_data;
   logic              push_ready;
   logic              pop_req;
   logic [IDX_W-1:0]  rd_idx;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic [IDX_W:0]    count;
   logic              empty;
   logic              full;
   logic              overflow;
   logic              hit_pulse;
   logic              miss_pulse;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   target_queue #(
      .DATA_W      (DATA_W),
      .DEPTH       (DEPTH),
      .TIME_LSB    (3),
      .TIME_W      (TIME_W),
      .MISS_WINDOW (8)
   ) dut (
      .pxl_clk    (pxl_clk),
      .reset_b    (reset_b),
      .cur_time   (cur_time),
      .push_valid (push_valid),
      .push_data  (push_data),
      .push_ready (push_ready),
      .pop_req    (pop_req),
      .rd_idx     (rd_idx),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .count      (count),
      .empty      (empty),
      .full       (full),
      .overflow   (overflow),
      .hit_pulse  (hit_pulse),
      .miss_pulse (miss_pulse)
   );

   always #5 pxl_clk = ~pxl_clk;

   typedef struct {
      logic        rst_b;
      logic        pv;
      logic [31:0] pd;
      logic        pop;
      logic [7:0]  ct;
      logic [2:0]  idx;
      logic [3:0]  cnt;
      logic        rdv;
      logic [31:0] rdd;
      logic        ovf;
      logic        hit;
      logic        miss;
   } vec_t;

   vec_t tbl[$];

   // Entry layout: id in [31:24], target time in [10:3]
   function automatic logic [31:0] mk(input int id, input int t);
      logic [7:0] id8;
      logic [7:0] t8;
      id8 = id[7:0];
      t8  = t[7:0];
      return {id8, 13'd0, t8, 3'd0};
   endfunction

   function automatic vec_t v(input logic rst_b, input logic pv, input logic [31:0] pd,
                              input logic pop, input int ct, input int idx,
                              input int cnt, input logic rdv, input logic [31:0] rdd,
                              input logic ovf, input logic hit, input logic miss);
      vec_t r;
      r.rst_b = rst_b; r.pv = pv; r.pd = pd; r.pop = pop;
      r.ct = ct[7:0]; r.idx = idx[2:0]; r.cnt = cnt[3:0];
      r.rdv = rdv; r.rdd = rdd; r.ovf = ovf; r.hit = hit; r.miss = miss;
      return r;
   endfunction

   task automatic chk(input string name, input int row, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
      end
   endtask

   task automatic drive(input vec_t r);
      reset_b    = r.rst_b;
      push_valid = r.pv;
      push_data  = r.pd;
      pop_req    = r.pop;
      cur_time   = r.ct;
      rd_idx     = r.idx;
   endtask

   task automatic check(input vec_t r, input int row);
      logic [3:0] cnt;
      cnt = r.cnt;
      chk("count",      row, 32'(count),      32'(cnt));
      chk("empty",      row, 32'(empty),      32'(cnt == 4'd0));
      chk("full",       row, 32'(full),       32'(cnt == 4'd8));
      chk("push_ready", row, 32'(push_ready), 32'(cnt != 4'd8));
      chk("rd_valid",   row, 32'(rd_valid),   32'(r.rdv));
      chk("overflow",   row, 32'(overflow),   32'(r.ovf));
      chk("hit_pulse",  row, 32'(hit_pulse),  32'(r.hit));
      chk("miss_pulse", row, 32'(miss_pulse), 32'(r.miss));
      if (r.rdv) chk("rd_data", row, rd_data, r.rdd);
   endtask

   initial begin
      vec_t r;

      // Reset state after two reset cycles
      tbl.push_back(v(1,0,0,0,0,0, 0,0,0, 0,0,0));
      // Three entries with times 10/20/30, read back oldest-first
      tbl.push_back(v(1,1,mk(1,10),0,0,0, 0,0,0, 0,0,0));
      tbl.push_back(v(1,1,mk(2,20),0,0,0, 1,1,mk(1,10), 0,0,0));
      tbl.push_back(v(1,1,mk(3,30),0,0,1, 2,1,mk(2,20), 0,0,0));
      tbl.push_back(v(1,0,0,0,0,2,        3,1,mk(3,30), 0,0,0));
      tbl.push_back(v(1,0,0,0,0,3,        3,0,0,        0,0,0));
      tbl.push_back(v(1,0,0,0,0,0,        3,1,mk(1,10), 0,0,0));
      // Fill to DEPTH
      for (int i = 0; i < 5; i++)
         tbl.push_back(v(1,1,mk(4+i,40+10*i),0,0,0, 3+i,1,mk(1,10), 0,0,0));
      // 9th push refused; overflow sticks; entry 9 absent
      tbl.push_back(v(1,1,mk(9,90),0,0,7, 8,1,mk(8,80), 0,0,0));
      tbl.push_back(v(1,0,0,0,0,7,        8,1,mk(8,80), 1,0,0));
      tbl.push_back(v(1,0,0,0,0,0,        8,1,mk(1,10), 1,0,0));
      // Three hits bring the head to time 40
      tbl.push_back(v(1,0,0,1,0,0,        8,1,mk(1,10), 1,0,0));
      tbl.push_back(v(1,0,0,1,0,0,        7,1,mk(2,20), 1,1,0));
      tbl.push_back(v(1,0,0,1,0,0,        6,1,mk(3,30), 1,1,0));
      tbl.push_back(v(1,0,0,0,0,0,        5,1,mk(4,40), 1,1,0));
      // Expiry boundary: 47 keeps, 48 expires
      tbl.push_back(v(1,0,0,0,47,0,       5,1,mk(4,40), 1,0,0));
      tbl.push_back(v(1,0,0,0,48,0,       5,1,mk(4,40), 1,0,0));
      tbl.push_back(v(1,0,0,0,48,0,       4,1,mk(5,50), 1,0,1));
      tbl.push_back(v(1,0,0,0,48,0,       4,1,mk(5,50), 1,0,0));
      // pop on an expired head plus push: hit wins, count unchanged
      tbl.push_back(v(1,1,mk(10,100),1,58,0, 4,1,mk(5,50), 1,0,0));
      tbl.push_back(v(1,0,0,0,0,3,        4,1,mk(10,100), 1,1,0));
      tbl.push_back(v(1,0,0,0,0,0,        4,1,mk(6,60),   1,0,0));
      // One-cycle reset with pop and push offered
      tbl.push_back(v(0,1,mk(11,110),1,0,0, 4,1,mk(6,60), 1,0,0));
      tbl.push_back(v(1,0,0,0,0,0,        0,0,0, 0,0,0));
      tbl.push_back(v(1,0,0,0,0,3,        0,0,0, 0,0,0));
      // Head time 250 across cur_time wrap: expires at 2, not at 255/0/1
      tbl.push_back(v(1,1,mk(12,250),0,240,0, 0,0,0, 0,0,0));
      tbl.push_back(v(1,0,0,0,255,0,      1,1,mk(12,250), 0,0,0));
      tbl.push_back(v(1,0,0,0,0,0,        1,1,mk(12,250), 0,0,0));
      tbl.push_back(v(1,0,0,0,1,0,        1,1,mk(12,250), 0,0,0));
      tbl.push_back(v(1,0,0,0,2,0,        1,1,mk(12,250), 0,0,0));
      tbl.push_back(v(1,0,0,0,2,0,        0,0,0, 0,0,1));
      // pop while empty is ignored
      tbl.push_back(v(1,0,0,1,2,0,        0,0,0, 0,0,0));
      tbl.push_back(v(1,0,0,0,2,0,        0,0,0, 0,0,0));

      // Reset sequence
      reset_b = 1'b0; push_valid = 1'b0; push_data = '0; pop_req = 1'b0;
      cur_time = '0; rd_idx = '0;
      repeat (2) @(posedge pxl_clk);

      foreach (tbl[i]) begin
         @(negedge pxl_clk);
         drive(tbl[i]);
         #1;
         check(tbl[i], i);
      end

      // Hand sequence: steady push+pop at count 1, pointers wrapping past DEPTH
      @(negedge pxl_clk);
      r = v(1,1,mk(20,0),0,2,0, 0,0,0, 0,0,0);
      drive(r);
      #1;
      check(r, 100);
      for (int i = 0; i < 10; i++) begin
         @(negedge pxl_clk);
         r = v(1,1,mk(21+i,0),1,2,0, 1,1,mk(20+i,0), 0,(i > 0),0);
         drive(r);
         #1;
         check(r, 101 + i);
      end
      @(negedge pxl_clk);
      r = v(1,0,0,0,2,0, 1,1,mk(30,0), 0,1,0);
      drive(r);
      #1;
      check(r, 111);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   // Absolute time bound so the run always ends
   initial begin
      #100000;
      $display("FAIL timeout: bench did not complete, got running expected finished");
      $fatal(1);
   end

endmodule
